// File: rtl/ue14500_pkg.sv
// Shared definitions for the UE14500 program sequencer: opcode encodings,
// sequencer state type and the program-word width helper.
package ue14500_pkg;

  localparam int OPC_W = 4;

  localparam logic [3:0] I_NOP0 = 4'h0;
  localparam logic [3:0] I_LD   = 4'h1;
  localparam logic [3:0] I_ADD  = 4'h2;
  localparam logic [3:0] I_SUB  = 4'h3;
  localparam logic [3:0] I_ONE  = 4'h4;
  localparam logic [3:0] I_NAND = 4'h5;
  localparam logic [3:0] I_OR   = 4'h6;
  localparam logic [3:0] I_XOR  = 4'h7;
  localparam logic [3:0] I_STO  = 4'h8;
  localparam logic [3:0] I_STOC = 4'h9;
  localparam logic [3:0] I_IEN  = 4'hA;
  localparam logic [3:0] I_OEN  = 4'hB;
  localparam logic [3:0] I_JMP  = 4'hC;
  localparam logic [3:0] I_RTN  = 4'hD;
  localparam logic [3:0] I_SKZ  = 4'hE;
  localparam logic [3:0] I_NOPF = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_ISSUE   = 2'd2,
    S_RESOLVE = 2'd3
  } seq_state_e;

  // Program word is {opcode, operand}; operand width follows the PC width.
  function automatic int word_width(input int addr_w);
    return OPC_W + addr_w;
  endfunction

endpackage

// File: rtl/ue14500_seq_stack.sv
// Circular return stack for the UE14500 sequencer. A push onto a full stack
// overwrites the oldest entry; a pop from an empty stack leaves state alone.
// Both cases raise a one-cycle error pulse.
module ue14500_seq_stack #(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(STACK_DEPTH - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(STACK_DEPTH);

  logic [PTR_W-1:0]  top_reg, top_next, prev_idx;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              full;
  logic [ADDR_W-1:0] entry_reg [STACK_DEPTH];

  // top_reg is the slot the next push lands in; when full that is the oldest entry.
  assign prev_idx  = (top_reg == '0) ? LAST_IDX : top_reg - 1'b1;
  assign pop_data  = entry_reg[prev_idx];
  assign full      = (cnt_reg == MAX_CNT);
  assign empty     = (cnt_reg == '0);
  assign overflow  = push & full;
  assign underflow = pop & ~push & empty;

  // Pointer/count update; push takes precedence over a simultaneous pop.
  always_comb begin
    top_next = top_reg;
    cnt_next = cnt_reg;
    if (push) begin
      top_next = (top_reg == LAST_IDX) ? '0 : top_reg + 1'b1;
      if (!full) cnt_next = cnt_reg + 1'b1;
    end else if (pop && !empty) begin
      top_next = prev_idx;
      cnt_next = cnt_reg - 1'b1;
    end
  end

  // Stack pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_reg <= '0;
      cnt_reg <= '0;
    end else begin
      top_reg <= top_next;
      cnt_reg <= cnt_next;
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) entry_reg[top_reg] <= push_data;
  end

endmodule

// File: rtl/ue14500_seq.sv
// UE14500 program sequencer: loadable program memory, PC, call/return stack.
// Each instruction takes FETCH -> ISSUE -> RESOLVE; the core's JMP/RTN/FLAGF
// strobes seen in RESOLVE decide the next PC and whether to halt.
// Optional breakpoint logic is built when SEQ_BREAKPOINT_EN is defined.
module ue14500_seq
  import ue14500_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run_i,
  input  logic                    step_i,
  input  logic                    prog_we_i,
  input  logic [ADDR_W-1:0]       prog_addr_i,
  input  logic [OPC_W+ADDR_W-1:0] prog_wdata_i,
  output logic [3:0]              instr_o,
  output logic [ADDR_W-1:0]       ioaddr_o,
  output logic                    instr_valid_o,
  input  logic                    core_jmp_i,
  input  logic                    core_rtn_i,
  input  logic                    core_flagf_i,
  output logic [ADDR_W-1:0]       pc_o,
  output logic                    busy_o,
`ifdef SEQ_BREAKPOINT_EN
  input  logic [ADDR_W-1:0]       bp_addr_i,
  output logic                    bp_hit_o,
`endif
  output logic                    stack_err_o
);

  localparam int WORD_W = word_width(ADDR_W);
  localparam int DEPTH  = 2 ** ADDR_W;

  seq_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              step_mode_reg, step_mode_next;
  logic              stack_err_reg, stack_err_next;
  logic [WORD_W-1:0] rd_word_reg;
  logic [WORD_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic              in_flight;

  logic              stk_push, stk_pop, stk_empty, stk_overflow, stk_underflow;
  logic [ADDR_W-1:0] stk_pop_data, stk_push_data;

`ifdef SEQ_BREAKPOINT_EN
  logic              bp_hit_reg, bp_hit_next;
  logic              bp_skip_reg, bp_skip_next;
`endif

  ue14500_seq_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (stk_push_data),
    .pop_data  (stk_pop_data),
    .empty     (stk_empty),
    .overflow  (stk_overflow),
    .underflow (stk_underflow)
  );

  // The fetched word is presented only while an instruction is in flight,
  // so instr_o reads NOP0 in IDLE/FETCH and after reset.
  assign in_flight     = (state_reg == S_ISSUE) || (state_reg == S_RESOLVE);
  assign instr_o       = in_flight ? rd_word_reg[WORD_W-1 -: OPC_W] : I_NOP0;
  assign ioaddr_o      = in_flight ? rd_word_reg[ADDR_W-1:0] : '0;
  assign instr_valid_o = (state_reg == S_ISSUE);
  assign pc_o          = pc_reg;
  assign busy_o        = (state_reg != S_IDLE);
  assign stack_err_o   = stack_err_reg;
  assign stk_push_data = pc_reg + 1'b1;
`ifdef SEQ_BREAKPOINT_EN
  assign bp_hit_o      = bp_hit_reg;
`endif

  // Program memory: host writes only in IDLE, registered read during FETCH.
  always_ff @(posedge clk) begin
    if (mem_we) mem[prog_addr_i] <= prog_wdata_i;
    if (state_reg == S_FETCH) rd_word_reg <= mem[pc_reg];
  end

  // Next-state, PC resolution and stack control.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    step_mode_next = step_mode_reg;
    stack_err_next = stack_err_reg;
    mem_we         = 1'b0;
    stk_push       = 1'b0;
    stk_pop        = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    bp_hit_next    = bp_hit_reg;
    bp_skip_next   = bp_skip_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        mem_we = prog_we_i;
        if (run_i || step_i) begin
          state_next     = S_FETCH;
          step_mode_next = step_i;
`ifdef SEQ_BREAKPOINT_EN
          bp_hit_next    = 1'b0;
`endif
        end
      end
      S_FETCH: begin
`ifdef SEQ_BREAKPOINT_EN
        // After a hit, the next fetch at that PC is let through once.
        if (pc_reg == bp_addr_i && !bp_skip_reg) begin
          state_next   = S_IDLE;
          bp_hit_next  = 1'b1;
          bp_skip_next = 1'b1;
        end else begin
          state_next   = S_ISSUE;
          bp_skip_next = 1'b0;
        end
`else
        state_next = S_ISSUE;
`endif
      end
      S_ISSUE: begin
        state_next = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (core_jmp_i) begin
          stk_push = 1'b1;
          pc_next  = ioaddr_o;
        end else if (core_rtn_i) begin
          stk_pop = 1'b1;
          pc_next = stk_empty ? '0 : stk_pop_data;
        end else begin
          pc_next = pc_reg + 1'b1;
        end
        if (stk_overflow || stk_underflow) stack_err_next = 1'b1;
        if (core_flagf_i || step_mode_reg || !run_i) state_next = S_IDLE;
        else                                         state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      pc_reg        <= '0;
      step_mode_reg <= 1'b0;
      stack_err_reg <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
      bp_hit_reg    <= 1'b0;
      bp_skip_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      step_mode_reg <= step_mode_next;
      stack_err_reg <= stack_err_next;
`ifdef SEQ_BREAKPOINT_EN
      bp_hit_reg    <= bp_hit_next;
      bp_skip_reg   <= bp_skip_next;
`endif
    end
  end

endmodule

// File: tb/tb_ue14500_seq.sv
// Self-checking bench for ue14500_seq: directed programs plus random programs,
// compared against a per-instruction reference model (array memory, queue stack).
module tb_ue14500_seq;
  import ue14500_pkg::*;

  localparam int AW    = 4;
  localparam int SD    = 2;
  localparam int DEPTH = 16;
`ifdef SEQ_BREAKPOINT_EN
  localparam int BP_ADDR = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run_i = 1'b0;
  logic          step_i = 1'b0;
  logic          prog_we_i = 1'b0;
  logic [AW-1:0] prog_addr_i = '0;
  logic [7:0]    prog_wdata_i = '0;
  logic [3:0]    instr_o;
  logic [AW-1:0] ioaddr_o;
  logic          instr_valid_o;
  logic          core_jmp_i = 1'b0;
  logic          core_rtn_i = 1'b0;
  logic          core_flagf_i = 1'b0;
  logic [AW-1:0] pc_o;
  logic          busy_o;
  logic          stack_err_o;
`ifdef SEQ_BREAKPOINT_EN
  logic [AW-1:0] bp_addr_i = 4'(BP_ADDR);
  logic          bp_hit_o;
`endif

  ue14500_seq #(.ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (run_i),
    .step_i       (step_i),
    .prog_we_i    (prog_we_i),
    .prog_addr_i  (prog_addr_i),
    .prog_wdata_i (prog_wdata_i),
    .instr_o      (instr_o),
    .ioaddr_o     (ioaddr_o),
    .instr_valid_o(instr_valid_o),
    .core_jmp_i   (core_jmp_i),
    .core_rtn_i   (core_rtn_i),
    .core_flagf_i (core_flagf_i),
    .pc_o         (pc_o),
    .busy_o       (busy_o),
`ifdef SEQ_BREAKPOINT_EN
    .bp_addr_i    (bp_addr_i),
    .bp_hit_o     (bp_hit_o),
`endif
    .stack_err_o  (stack_err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] m_mem [DEPTH];
  int         m_pc;
  int         m_stack [$];
  bit         m_err;
  bit         m_step;
  bit         m_bp_hit;
  bit         m_bp_skip;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_err = 1'b0;
    m_step = 1'b0;
    m_bp_hit = 1'b0;
    m_bp_skip = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_i = 1'b0;
    step_i = 1'b0;
    #2;
    check("rst_pc", pc_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_valid", instr_valid_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_err", stack_err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic load(input int a, input logic [7:0] w);
    prog_we_i = 1'b1;
    prog_addr_i = a[AW-1:0];
    prog_wdata_i = w;
    tick();
    prog_we_i = 1'b0;
    m_mem[a] = w;
  endtask

  task automatic fill(input logic [7:0] w);
    for (int a = 0; a < DEPTH; a++) load(a, w);
  endtask

  task automatic start(input bit use_step);
    run_i = !use_step;
    step_i = use_step;
    m_step = use_step;
    m_bp_hit = 1'b0;
    tick();
    step_i = 1'b0;
    check("start_busy", busy_o, 1);
  endtask

  // Precondition: DUT in FETCH. Runs one instruction acting as the core.
  task automatic do_instr(input bit rand_strb, input bit keep_run, output bit halted);
    logic [7:0] w;
    logic [3:0] op;
    logic [3:0] opd;
    bit j, r, f;
    int old_pc;
    halted = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    if (m_pc == BP_ADDR && !m_bp_skip) begin
      tick();
      run_i = 1'b0;
      m_bp_hit = 1'b1;
      m_bp_skip = 1'b1;
      halted = 1'b1;
      check("bp_busy", busy_o, 0);
      check("bp_hit", bp_hit_o, 1);
      check("bp_pc", pc_o, m_pc);
      $display("[TB] breakpoint at pc=%0h", m_pc);
      return;
    end
    m_bp_skip = 1'b0;
`endif
    check("fetch_valid", instr_valid_o, 0);
    tick();
    w = m_mem[m_pc];
    op = w[7:4];
    opd = w[3:0];
    check("issue_valid", instr_valid_o, 1);
    check("issue_op", instr_o, op);
    check("issue_opd", ioaddr_o, opd);
    check("issue_pc", pc_o, m_pc);
    run_i = keep_run;
    // Host write attempt while busy must be ignored.
    prog_we_i = 1'b1;
    prog_addr_i = m_pc[AW-1:0];
    prog_wdata_i = ~w;
    tick();
    check("resolve_valid", instr_valid_o, 0);
    check("resolve_op", instr_o, op);
    check("resolve_opd", ioaddr_o, opd);
    if (rand_strb) begin
      j = (op == I_JMP) && ($urandom % 4 != 0);
      r = ((op == I_RTN) && ($urandom % 4 != 0)) || (j && ($urandom % 8 == 0));
      f = (op == I_NOPF) && ($urandom % 4 != 0);
    end else begin
      j = (op == I_JMP);
      r = (op == I_RTN);
      f = (op == I_NOPF);
    end
    core_jmp_i = j;
    core_rtn_i = r;
    core_flagf_i = f;
    tick();
    core_jmp_i = 1'b0;
    core_rtn_i = 1'b0;
    core_flagf_i = 1'b0;
    prog_we_i = 1'b0;
    old_pc = m_pc;
    if (j) begin
      m_stack.push_back((m_pc + 1) % DEPTH);
      if (m_stack.size() > SD) begin
        void'(m_stack.pop_front());
        m_err = 1'b1;
      end
      m_pc = int'(opd);
    end else if (r) begin
      if (m_stack.size() == 0) begin
        m_pc = 0;
        m_err = 1'b1;
      end else begin
        m_pc = m_stack.pop_back();
      end
    end else begin
      m_pc = (m_pc + 1) % DEPTH;
    end
    halted = f || m_step || !keep_run;
    if (halted) run_i = 1'b0;
    check("pc", pc_o, m_pc);
    check("busy", busy_o, !halted);
    check("stack_err", stack_err_o, m_err);
    check("post_valid", instr_valid_o, 0);
`ifdef SEQ_BREAKPOINT_EN
    check("bp_clear", bp_hit_o, m_bp_hit);
`endif
    $display("[TB] pc=%0h op=%0h opd=%0h jmp=%0b rtn=%0b flagf=%0b -> pc=%0h err=%0b halt=%0b",
             old_pc, op, opd, j, r, f, m_pc, m_err, halted);
  endtask

  // Start, then execute until halt; run is dropped on the last allowed slot.
  task automatic run_prog(input bit use_step, input bit rand_strb, input int max_n);
    bit halted;
    bit keep;
    start(use_step);
    for (int i = 0; i < max_n; i++) begin
      keep = (i < max_n - 1);
      if (rand_strb && ($urandom % 10 == 0)) keep = 1'b0;
      do_instr(rand_strb, keep, halted);
      if (halted) break;
    end
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    do_reset();

    // Straight-line program ending in NOPF: halts with pc=3.
    fill({I_LD, 4'h0});
    load(0, {I_ONE, 4'h0});
    load(1, {I_OEN, 4'h1});
    load(2, {I_NOPF, 4'h0});
    run_prog(1'b0, 1'b0, 10);
    check("halt_pc", pc_o, m_pc);

    // Single step from PC 0, then re-run to confirm memory was not written while busy.
    do_reset();
    run_prog(1'b1, 1'b0, 5);
    check("step_idle", busy_o, 0);
    do_reset();
    run_prog(1'b1, 1'b0, 5);

    // Call to 0xA and return to 3.
    do_reset();
    fill({I_LD, 4'h0});
    load(2, {I_JMP, 4'hA});
    load(4'hA, {I_RTN, 4'h0});
    load(3, {I_NOPF, 4'h0});
    run_prog(1'b0, 1'b0, 20);

    // Nested calls overflow a depth-2 stack, then unwinding underflows to PC 0.
    do_reset();
    fill({I_LD, 4'h0});
    load(0, {I_JMP, 4'h4});
    load(4, {I_JMP, 4'h8});
    load(8, {I_JMP, 4'hC});
    load(4'hC, {I_RTN, 4'h0});
    load(9, {I_RTN, 4'h0});
    load(5, {I_RTN, 4'h0});
    run_prog(1'b0, 1'b0, 6);
    check("underflow_err", stack_err_o, 1);

    // PC wrap from 0xF to 0, with run dropped during the second issue.
    do_reset();
    fill({I_LD, 4'h0});
    load(0, {I_JMP, 4'hF});
    run_prog(1'b0, 1'b0, 2);

    // Random programs, random strobes, random step/run and early stops.
    do_reset();
    for (int a = 0; a < DEPTH; a++) load(a, 8'($urandom));
    for (int k = 0; k < 60; k++) begin
      if ($urandom % 4 == 0) load(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
      run_prog(($urandom % 4) == 0, 1'b1, int'($urandom_range(1, 12)));
    end

    // Asynchronous reset in the middle of RESOLVE.
    start(1'b0);
    if (!(m_pc == 2 && !m_bp_skip)) begin
      tick();
      tick();
      check("pre_rst_valid", instr_valid_o, 0);
    end
    do_reset();
    check("post_rst_idle", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
